mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 106 ++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS-style HI/LO unit doing shift-add multiply and restoring divide, one bit per cycle.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   div_q, neg_q, rneg_q, dz_q, done_q, dzo_q;
  logic [WIDTH-1:0]       opnd_q, hi_q, lo_q;
  logic [2*WIDTH-1:0]     acc_q, acc_d, fix_d;
  logic                   sa, sb;
  logic [WIDTH-1:0]       abs_a, abs_b, rem_fix, quo_fix;
  logic [WIDTH:0]         mul_sum, div_try;
  always_comb begin
    sa      = ~op[0] & src_a[WIDTH-1];
    sb      = ~op[0] & src_b[WIDTH-1];
    abs_a   = sa ? -src_a : src_a;
    abs_b   = sb ? -src_b : src_b;
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_try = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
    acc_d   = !div_q ? {mul_sum, acc_q[WIDTH-1:1]} :
              div_try[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0} :
              {div_try[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    rem_fix = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    quo_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    fix_d   = div_q ? {rem_fix, quo_fix} : (neg_q ? -acc_q : acc_q);
  end
  // FIX spends one cycle on sign correction and one committing HI/LO
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dzo_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dzo_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hi_we) hi_q <= wd;
          if (lo_we) lo_q <= wd;
          if (start) begin
            state_q <= CALC;
            cnt_q   <= '0;
            div_q   <= op[1];
            neg_q   <= sa ^ sb;
            rneg_q  <= sa;
            dz_q    <= op[1] && src_b == '0;
            opnd_q  <= op[1] ? abs_b : abs_a;
            acc_q   <= {{WIDTH{1'b0}}, op[1] ? abs_a : abs_b};
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (&cnt_q) state_q <= FIX;
        end
        FIX: begin
          if (cnt_q == '0) begin
            acc_q <= fix_d;
            cnt_q <= CNT_W'(1);
          end else begin
            if (!dz_q) begin
              hi_q <= acc_q[2*WIDTH-1:WIDTH];
              lo_q <= acc_q[WIDTH-1:0];
            end
            done_q  <= 1'b1;
            dzo_q   <= dz_q;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = state_q != IDLE;
  assign done        = done_q;
  assign div_by_zero = dzo_q;
endmodule
